// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: state encodings and phase classifiers.
// The state FSM and the phase timer both import this package.
package tl_pkg;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S0 = 3'd0;
  localparam logic [STATE_W-1:0] S1 = 3'd1;
  localparam logic [STATE_W-1:0] S2 = 3'd2;
  localparam logic [STATE_W-1:0] S3 = 3'd3;

  function automatic logic is_green(input logic [STATE_W-1:0] s);
    return (s == S0) || (s == S2);
  endfunction

  function automatic logic is_yellow(input logic [STATE_W-1:0] s);
    return (s == S1) || (s == S3);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear and enable together restart counting from one; clear alone parks at zero.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  logic [W-1:0] w_base;

  assign w_base = i_clr ? '0 : r_q;
  assign o_q    = r_q;

  always_ff @(posedge clk) begin
    if (rst)
      r_q <= '0;
    else if (!i_en)
      r_q <= w_base;
    else if (&w_base)
      r_q <= w_base;
    else
      r_q <= w_base + 1'b1;
  end
endmodule

// File: rtl/phase_timer.sv
// Per-phase duration timer: raises the green/yellow done strobes for the state FSM,
// grants one pedestrian green extension per phase and drives the display countdown.
import tl_pkg::*;

module phase_timer #(
  parameter int GREEN_TIME  = 10,
  parameter int YELLOW_TIME = 3,
  parameter int PED_EXT     = 5,
  parameter int CNT_W       = 8
) (
  input  logic               clk_1hz,
  input  logic               rst,
  input  logic [STATE_W-1:0] state,
  input  logic               emergency_A,
  input  logic               emergency_B,
  input  logic               ped_req,
  output logic               time1,
  output logic               time2,
  output logic [CNT_W-1:0]   remaining,
  output logic               ped_ack
);
  localparam logic [CNT_W-1:0] LIM_G    = CNT_W'(GREEN_TIME);
  localparam logic [CNT_W-1:0] LIM_GX   = CNT_W'(GREEN_TIME + PED_EXT);
  localparam logic [CNT_W-1:0] LIM_Y    = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(GREEN_TIME - 1);

  if (GREEN_TIME < 1 || YELLOW_TIME < 1 || PED_EXT < 0 ||
      GREEN_TIME + PED_EXT > (1 << CNT_W) - 1) begin : g_bad_params
    $error("phase_timer: phase lengths do not fit CNT_W");
  end

  logic [STATE_W-1:0] r_prev;
  logic               r_ext;
  logic               r_ped_ack;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_green, w_yellow, w_emerg, w_restart;
  logic               w_ext_eff, w_grant, w_done;
  logic [CNT_W-1:0]   w_elapsed, w_limit;

  assign w_green   = is_green(state);
  assign w_yellow  = is_yellow(state);
  assign w_emerg   = emergency_A | emergency_B;
  assign w_restart = (state != r_prev) | w_emerg;
  assign w_elapsed = w_restart ? '0 : w_cnt;
  assign w_limit   = w_green ? (r_ext ? LIM_GX : LIM_G) : LIM_Y;
  assign w_done    = (w_elapsed == w_limit - 1'b1);

  // Emergency parks the count at zero so the forced phase runs its full length on release.
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk_1hz),
    .rst   (rst),
    .i_clr (w_restart),
    .i_en  (!w_emerg),
    .o_q   (w_cnt)
  );

  assign w_ext_eff = r_ext & !w_restart;
  assign w_grant   = w_green & !w_emerg & !w_ext_eff & ped_req & (w_elapsed < PED_LAST);

  assign time1     = !rst & !w_emerg & w_green  & w_done;
  assign time2     = !rst & !w_emerg & w_yellow & w_done;
  assign remaining = ((w_green | w_yellow) & !w_emerg & !rst) ? w_limit - w_elapsed : '0;
  assign ped_ack   = r_ped_ack;

  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      r_prev    <= S0;
      r_ext     <= 1'b0;
      r_ped_ack <= 1'b0;
    end else begin
      r_prev    <= state;
      r_ped_ack <= w_grant;
      if (w_grant)
        r_ext <= 1'b1;
      else if (w_restart)
        r_ext <= 1'b0;
    end
  end
endmodule
